// File: rtl/pwm_modulate.sv
// Pulse-width modulator: serialises DATA_W-bit words MSB-first, one fixed-length symbol per bit.
// Define PWM_MODULATE_PARITY_EN to append an even-parity symbol after each word.
module pwm_modulate #(
  parameter int DATA_W     = 8,
  parameter int SYMBOL_LEN = 24,
  parameter int SHORT_HIGH = 6,
  parameter int LONG_HIGH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mod_signal,
  output logic              busy
);

`ifdef PWM_MODULATE_PARITY_EN
  localparam int NSYM = DATA_W + 1;
`else
  localparam int NSYM = DATA_W;
`endif
  localparam int SC_W = $clog2(SYMBOL_LEN);
  localparam int BC_W = $clog2(DATA_W + 2);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t            state, state_d;
  logic [NSYM-1:0]   shreg, shreg_d, load_word;
  logic [BC_W-1:0]   bit_cnt, bit_cnt_d;
  logic [SC_W-1:0]   sym_cnt, sym_cnt_d, hi_last;
  logic              mod_d, sym_end, last_sym, accept;

`ifdef PWM_MODULATE_PARITY_EN
  assign load_word = {in_data, ^in_data};
`else
  assign load_word = in_data;
`endif

  assign hi_last  = shreg[NSYM-1] ? SC_W'(SHORT_HIGH - 1) : SC_W'(LONG_HIGH - 1);
  assign sym_end  = (sym_cnt == SC_W'(SYMBOL_LEN - 1));
  assign last_sym = (bit_cnt == BC_W'(1));
  // Ready in the final cycle of the final symbol lets words run back-to-back.
  assign in_ready = (state == IDLE) || (state == LOW && sym_end && last_sym);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

  always_comb begin
    state_d   = state;
    shreg_d   = shreg;
    bit_cnt_d = bit_cnt;
    sym_cnt_d = sym_cnt;
    mod_d     = mod_signal;
    unique case (state)
      IDLE: begin
        mod_d = 1'b0;
        if (accept) begin
          shreg_d   = load_word;
          bit_cnt_d = BC_W'(NSYM);
          sym_cnt_d = '0;
          mod_d     = 1'b1;
          state_d   = HIGH;
        end
      end
      HIGH: begin
        sym_cnt_d = sym_cnt + 1'b1;
        if (sym_cnt == hi_last) begin
          mod_d   = 1'b0;
          state_d = LOW;
        end
      end
      LOW: begin
        sym_cnt_d = sym_cnt + 1'b1;
        if (sym_end) begin
          sym_cnt_d = '0;
          shreg_d   = shreg << 1;
          bit_cnt_d = bit_cnt - 1'b1;
          if (!last_sym) begin
            mod_d   = 1'b1;
            state_d = HIGH;
          end else if (accept) begin
            shreg_d   = load_word;
            bit_cnt_d = BC_W'(NSYM);
            mod_d     = 1'b1;
            state_d   = HIGH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        mod_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      sym_cnt    <= '0;
      mod_signal <= 1'b0;
    end else begin
      state      <= state_d;
      shreg      <= shreg_d;
      bit_cnt    <= bit_cnt_d;
      sym_cnt    <= sym_cnt_d;
      mod_signal <= mod_d;
    end
  end

endmodule

// File: tb/tb_pwm_modulate.sv
// Bench for pwm_modulate: the expected line is built as a per-cycle queue of levels from the encoding rules.
module tb_pwm_modulate;
  localparam int DATA_W = 8, SYMBOL_LEN = 24, SHORT_HIGH = 6, LONG_HIGH = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready, mod_signal, busy;

  int   checks = 0, errors = 0;
  logic line_q[$];
  int   widths[$];
  int   run = 0;

  pwm_modulate #(.DATA_W(DATA_W), .SYMBOL_LEN(SYMBOL_LEN), .SHORT_HIGH(SHORT_HIGH),
                 .LONG_HIGH(LONG_HIGH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mod_signal(mod_signal), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One symbol is W high cycles followed by SYMBOL_LEN-W low cycles.
  task automatic push_sym(input logic b);
    int w = b ? SHORT_HIGH : LONG_HIGH;
    for (int i = 0; i < SYMBOL_LEN; i++) line_q.push_back(i < w);
  endtask

  task automatic push_word(input logic [DATA_W-1:0] d);
    for (int i = DATA_W - 1; i >= 0; i--) push_sym(d[i]);
`ifdef PWM_MODULATE_PARITY_EN
    push_sym(^d);
`endif
  endtask

  // One clock cycle: check outputs mid-cycle, drive inputs, advance the model.
  task automatic step(input logic v, input logic [DATA_W-1:0] d, output logic acc);
    logic exp_m, exp_r;
    @(negedge clk);
    exp_m = (line_q.size() > 0) ? line_q[0] : 1'b0;
    exp_r = (line_q.size() <= 1);
    chk("mod_signal", mod_signal, exp_m);
    chk("busy", busy, line_q.size() > 0);
    chk("in_ready", in_ready, exp_r);
    if (mod_signal === 1'b1) run++;
    else if (run > 0) begin widths.push_back(run); run = 0; end
    in_valid = v;
    in_data  = d;
    acc = v && exp_r;
    if (line_q.size() > 0) void'(line_q.pop_front());
    if (acc) push_word(d);
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, '0, a);
  endtask

  task automatic send(input logic [DATA_W-1:0] d);
    logic a = 1'b0;
    int   n = 0;
    while (!a && n < 600) begin step(1'b1, d, a); n++; end
    if (!a) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_widths(input string tag, input int exp[$]);
    chk({tag, "_count"}, widths.size(), exp.size());
    for (int i = 0; i < exp.size() && i < widths.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), widths[i], exp[i]);
  endtask

  initial begin
    int exp_a5[$], exp_81[$], exp_a4[$];
    exp_a5 = '{6, 16, 6, 16, 16, 6, 16, 6};
    exp_81 = '{6, 16, 16, 16, 16, 16, 16, 6};
`ifdef PWM_MODULATE_PARITY_EN
    exp_a5.push_back(16);
    exp_81.push_back(16);
    exp_a4 = '{6, 16, 6, 16, 16, 6, 16, 16, 6};
`endif

    #2;
    chk("rst_mod", mod_signal, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    @(negedge clk); rst = 1'b0;

    // Single word 0xA5, then idle until fully drained.
    widths = {}; send(8'hA5); idle(240);
    chk_widths("a5", exp_a5);

`ifdef PWM_MODULATE_PARITY_EN
    widths = {}; send(8'hA4); idle(260);
    chk_widths("a4", exp_a4);
`endif

    // Back-to-back: second word waits on in_ready with in_valid held.
    send(8'hFF); send(8'h00); idle(420);

    // Backpressure during symbol 3 of a running word.
    send(8'($urandom)); idle(3 * SYMBOL_LEN + 5); send(8'h3C); idle(240);

    // Reset during the 10th high cycle of the first 0-bit of 0xA5 (cycle 34).
    send(8'hA5); idle(33);
    @(negedge clk);
    chk("pre_rst_mod", mod_signal, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_mod", mod_signal, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ready", in_ready, 1'b1);
    line_q = {}; run = 0;
    @(negedge clk); rst = 1'b0;
    widths = {}; send(8'h81); idle(240);
    chk_widths("x81", exp_81);

    // Randomized words with random gaps.
    for (int k = 0; k < 20; k++) begin
      if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 40));
      send(8'($urandom));
    end
    idle(260);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pwm_modulate.md
Name: pwm_modulate

Overview:
- Transmit-side pulse-width modulator. It sits directly upstream of the team's pulse-width demodulator and drives its now_signal input on the same clk.
- It accepts parallel data words over a valid/ready handshake and serialises them MSB-first.
- Each bit becomes one fixed-length symbol: a high pulse followed by low time. A short pulse encodes 1; a long pulse encodes 0.
- The line idles low.

Parameters:
- DATA_W, 8, width of each accepted data word.
- SYMBOL_LEN, 24, clk cycles per bit symbol (high time plus low time).
- SHORT_HIGH, 6, high cycles for a 1 bit. Must be ≤12 so the demodulator decodes 1.
- LONG_HIGH, 16, high cycles for a 0 bit. Must be 13..16: the demodulator's 4-bit counter must not wrap.
- Legal ranges: 1 ≤ SHORT_HIGH < LONG_HIGH < SYMBOL_LEN, so every symbol has ≥1 low cycle.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  DATA_W  word to transmit; sampled on an accept.
- in_valid  input  1  upstream has a word on in_data.
- in_ready  output  1  block can accept a word this cycle. Accept = in_valid && in_ready at a posedge.
- mod_signal  output  1  registered modulated line to the demodulator.
- busy  output  1  high while a word is being transmitted (state HIGH or LOW).

Behaviour:
- Reset (async, immediate): state=IDLE, mod_signal=0, busy=0, in_ready=1, all counters and the shift register cleared.
- Reset asserted mid-symbol: line drops low at once. The partial word is discarded and is not resent.
- Registers:
  - shreg, DATA_W bits, MSB transmitted first.
  - bit_cnt, counts symbols remaining in the word.
  - sym_cnt, 0..SYMBOL_LEN-1, position inside the current symbol.
- FSM states: IDLE, HIGH, LOW.
- IDLE:
  - mod_signal=0, in_ready=1.
  - On accept: load shreg<=in_data, bit_cnt<=DATA_W, sym_cnt<=0, mod_signal<=1, go to HIGH.
  - Latency: mod_signal is high in the first cycle after the accepting edge.
- HIGH:
  - mod_signal=1, sym_cnt increments every cycle.
  - Target width: W = SHORT_HIGH if shreg MSB=1, else LONG_HIGH.
  - When sym_cnt==W-1: mod_signal<=0, go to LOW. The line is high for exactly W cycles.
- LOW:
  - mod_signal=0, sym_cnt increments.
  - End of symbol is when sym_cnt==SYMBOL_LEN-1. At that edge: sym_cnt<=0, shift shreg left by 1, bit_cnt decrements.
  - If bits remain: mod_signal<=1, go to HIGH.
  - If this was the last bit, go to IDLE.
- Back-to-back words:
  - in_ready is also 1 during the final cycle of the final symbol's LOW phase.
  - An accept there loads the new word and goes straight to HIGH, with no idle gap. Symbol spacing stays exactly SYMBOL_LEN.
- in_ready is 0 in all other HIGH/LOW cycles. A held in_valid waits; in_data may change freely while not accepted.
- busy = (state != IDLE).
- Word duration: DATA_W*SYMBOL_LEN cycles (192 at defaults).
- Counter widths: $clog2(SYMBOL_LEN) for sym_cnt and $clog2(DATA_W+2) for bit_cnt. No wrap within the legal parameter range.

Optional Feature:
- Macro: PWM_MODULATE_PARITY_EN.
- When defined: after the DATA_W data symbols, one extra symbol carries even parity (XOR of the accepted word). It uses the same encoding (1 = short, 0 = long). Word duration becomes (DATA_W+1)*SYMBOL_LEN. in_ready asserts in the last cycle of the parity symbol instead.
- When undefined: no parity logic; exactly DATA_W symbols per word.

Test Plan:
- Single word: reset, then accept 0xA5 at cycle 0.
  - mod_signal high widths, in order: 6,16,6,16,16,6,16,6.
  - Rising edges at cycles 1,25,49,...,169.
  - busy high cycles 1..192; in_ready returns to 1 at cycle 192.
- Back-to-back: hold in_valid with 0xFF then 0x00.
  - Second accept occurs in the last LOW cycle of the first word.
  - 16 contiguous symbols: eight width-6 pulses then eight width-16 pulses, no extra low gap.
- Backpressure: assert in_valid with 0x3C during symbol 3 of a running word.
  - in_ready stays 0 and the word is not accepted until the end-of-word cycle.
  - 0x3C is then sent intact.
- Reset mid-operation: assert rst during the 10th high cycle of a 0-bit symbol.
  - mod_signal goes 0 in the same cycle without waiting for a clock; busy=0, in_ready=1.
  - After release, a new 0x81 transmits correctly: widths 6,16,16,16,16,16,16,6.
- Loopback with demodulator on the same clk, words 0x00, 0xFF, 0x5A, 0xC3: demodulator output_data reproduces every bit in order, one update per symbol.
- With PWM_MODULATE_PARITY_EN, word 0xA5: 9th symbol has width 16 (parity 0). Word 0xA4: 9th symbol has width 6 (parity 1).
